// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - width and pointer helpers shared by the fifo_hs files
package fifo_pkg;

  // Pointer width; a 2-entry FIFO still needs one pointer bit
  function automatic int ptr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  // Occupancy width able to hold 0..depth inclusive
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Wrap-aware increment: depth-1 goes back to 0 so non-power-of-2 depths work
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATAW storage, sync write, async read, no reset
module fifo_mem #(
  parameter int DATAW = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [DATAW-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [DATAW-1:0] rd_data_o
);

  logic [DATAW-1:0] mem_q [DEPTH];

  // Write port; contents are never cleared, only pointers are
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fifo_hs.sv
// rtl/fifo_hs.sv - valid/ready FIFO with occupancy, thresholds, flush and fall-through
module fifo_hs
  import fifo_pkg::*;
#(
  parameter int DATAW        = 8,
  parameter int DEPTH        = 4,
  parameter int AF_THRESH    = DEPTH - 1,
  parameter int AE_THRESH    = 1,
  parameter int FALL_THROUGH = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [DATAW-1:0]          in_data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATAW-1:0]          out_data_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      almost_full_o,
  output logic                      almost_empty_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam bit FT = (FALL_THROUGH != 0);

  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "fifo_hs: DEPTH must be at least 2");
  end
  if (AF_THRESH > DEPTH) begin : g_bad_af
    $fatal(1, "fifo_hs: AF_THRESH must not exceed DEPTH");
  end
  if (AE_THRESH >= DEPTH) begin : g_bad_ae
    $fatal(1, "fifo_hs: AE_THRESH must be below DEPTH");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DATAW-1:0] rd_data;
  logic             full, empty;
  logic             push, pop, bypass;
  logic             wr_en, rd_adv;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);

  // A full FIFO refuses a push even if a pop happens in the same cycle
  assign in_ready_o  = !full;
  assign out_valid_o = !empty || (FT && in_valid_i);

  assign push   = in_valid_i && in_ready_o;
  assign pop    = out_valid_o && out_ready_i;
  // Empty fall-through with both sides ready: data never touches storage
  assign bypass = FT && empty && push && pop;
  assign wr_en  = push && !bypass && !flush_i;
  assign rd_adv = pop && !empty && !flush_i;

  assign out_data_o     = (FT && empty) ? in_data_i : rd_data;
  assign count_o        = count_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count_q >= CW'(AF_THRESH));
  assign almost_empty_o = (count_q <= CW'(AE_THRESH));

  // Next pointer/count; flush wins over any push or pop in the same cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
      end
      if (rd_adv) begin
        rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
      end
      count_d = count_q + CW'(wr_en) - CW'(rd_adv);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_mem #(
    .DATAW (DATAW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (in_data_i),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

`ifndef SYNTHESIS
  logic [CW-1:0] ptr_diff;

  // Occupancy implied by the pointers; equal pointers mean empty or full
  always_comb begin
    ptr_diff = '0;
    if (wr_ptr_q >= rd_ptr_q) begin
      ptr_diff = CW'(wr_ptr_q) - CW'(rd_ptr_q);
    end else begin
      ptr_diff = CW'(DEPTH) + CW'(wr_ptr_q) - CW'(rd_ptr_q);
    end
  end

  a_count_max: assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= CW'(DEPTH));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && full));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop && empty && !FT));
  a_count_ptrs: assert property (@(posedge clk_i) disable iff (rst_i)
    count_q == ((ptr_diff == '0 && full) ? CW'(DEPTH) : ptr_diff));

  logic [1:0]       trk_arm_q;
  logic [CW-1:0]    trk_ahead_q [2];
  logic [DATAW-1:0] trk_val_q   [2];

  // Two trackers follow stored values to the head; the second arms only behind the first
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trk_arm_q <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (trk_arm_q[k]) begin
          if (flush_i) begin
            trk_arm_q[k] <= 1'b0;
          end else if (rd_adv) begin
            if (trk_ahead_q[k] == '0) begin
              trk_arm_q[k] <= 1'b0;
            end else begin
              trk_ahead_q[k] <= trk_ahead_q[k] - 1'b1;
            end
          end
        end else if (wr_en && (k == 0 || trk_arm_q[0])) begin
          trk_arm_q[k]   <= 1'b1;
          trk_val_q[k]   <= in_data_i;
          trk_ahead_q[k] <= count_q - CW'(rd_adv);
        end
      end
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_order
    a_order: assert property (@(posedge clk_i) disable iff (rst_i)
      (trk_arm_q[k] && trk_ahead_q[k] == '0 && rd_adv) |-> (out_data_o == trk_val_q[k]));
  end
`endif

endmodule

// File: tb/tb_fifo_hs.sv
// tb/tb_fifo_hs.sv - directed table-driven bench for fifo_hs
module tb_fifo_hs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       flush = 1'b0, vld = 1'b0, rdy = 1'b0;
  logic [7:0] din = '0;
  logic       in_ready, out_valid, full, empty, af, ae;
  logic [7:0] dout;
  logic [2:0] count;

  logic       f_flush = 1'b0, f_vld = 1'b0, f_rdy = 1'b0;
  logic [7:0] f_din = '0;
  logic       f_in_ready, f_out_valid, f_full, f_empty, f_af, f_ae;
  logic [7:0] f_dout;
  logic [2:0] f_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_hs #(.DATAW(8), .DEPTH(5), .FALL_THROUGH(0)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(vld), .in_ready_o(in_ready), .in_data_i(din),
    .out_valid_o(out_valid), .out_ready_i(rdy), .out_data_o(dout),
    .count_o(count), .full_o(full), .empty_o(empty),
    .almost_full_o(af), .almost_empty_o(ae)
  );

  fifo_hs #(.DATAW(8), .DEPTH(4), .FALL_THROUGH(1)) u_ft (
    .clk_i(clk), .rst_i(rst), .flush_i(f_flush),
    .in_valid_i(f_vld), .in_ready_o(f_in_ready), .in_data_i(f_din),
    .out_valid_o(f_out_valid), .out_ready_i(f_rdy), .out_data_o(f_dout),
    .count_o(f_count), .full_o(f_full), .empty_o(f_empty),
    .almost_full_o(f_af), .almost_empty_o(f_ae)
  );

  typedef struct {
    logic       flush;
    logic       vld;
    logic [7:0] din;
    logic       rdy;
    int         cnt;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic f, input logic v, input logic [7:0] d,
                     input logic r, input int c, input logic [7:0] o);
    vec_t t;
    t.flush = f; t.vld = v; t.din = d; t.rdy = r; t.cnt = c; t.dout = o;
    vecs.push_back(t);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected {full, empty, in_ready, out_valid, almost_full, almost_empty} for DEPTH=5, AF=4, AE=1
  function automatic logic [5:0] exp_flags(input int c);
    return {c == 5, c == 0, c != 5, c != 0, c >= 4, c <= 1};
  endfunction

  task automatic check_dut(input string nm, input int c, input logic [7:0] o);
    check({nm, " count"}, 32'(count), 32'(c));
    check({nm, " flags"}, 32'({full, empty, in_ready, out_valid, af, ae}), 32'(exp_flags(c)));
    if (c != 0) check({nm, " data"}, 32'(dout), 32'(o));
  endtask

  // Outputs are checked 1 ns after inputs change at the falling edge, before the next rising edge
  task automatic drive(input logic f, input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    flush = f; vld = v; din = d; rdy = r;
    #1;
  endtask

  task automatic ft_drive(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    f_vld = v; f_din = d; f_rdy = r;
    #1;
  endtask

  task automatic ft_check(input string nm, input int c, input logic v, input logic [7:0] o);
    check({nm, " ft count"}, 32'(f_count), 32'(c));
    check({nm, " ft valid"}, 32'(f_out_valid), 32'(v));
    if (v) check({nm, " ft data"}, 32'(f_dout), 32'(o));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // fill to full, refused sixth push, drain in order
    add(0, 0, 8'h00, 0, 0, 8'h00);
    add(0, 1, 8'h11, 0, 0, 8'h00);
    add(0, 1, 8'h22, 0, 1, 8'h11);
    add(0, 1, 8'h33, 0, 2, 8'h11);
    add(0, 1, 8'h44, 0, 3, 8'h11);
    add(0, 1, 8'h55, 0, 4, 8'h11);
    add(0, 1, 8'h66, 0, 5, 8'h11);
    add(0, 0, 8'h00, 0, 5, 8'h11);
    add(0, 0, 8'h00, 1, 5, 8'h11);
    add(0, 0, 8'h00, 1, 4, 8'h22);
    add(0, 0, 8'h00, 1, 3, 8'h33);
    add(0, 0, 8'h00, 1, 2, 8'h44);
    add(0, 0, 8'h00, 1, 1, 8'h55);
    add(0, 0, 8'h00, 0, 0, 8'h00);
    // wrap: push 3, pop 3, push 5 across index 4 -> 0, pop 5
    add(0, 1, 8'hA1, 0, 0, 8'h00);
    add(0, 1, 8'hA2, 0, 1, 8'hA1);
    add(0, 1, 8'hA3, 0, 2, 8'hA1);
    add(0, 0, 8'h00, 1, 3, 8'hA1);
    add(0, 0, 8'h00, 1, 2, 8'hA2);
    add(0, 0, 8'h00, 1, 1, 8'hA3);
    add(0, 1, 8'hB1, 0, 0, 8'h00);
    add(0, 1, 8'hB2, 0, 1, 8'hB1);
    add(0, 1, 8'hB3, 0, 2, 8'hB1);
    add(0, 1, 8'hB4, 0, 3, 8'hB1);
    add(0, 1, 8'hB5, 0, 4, 8'hB1);
    add(0, 0, 8'h00, 1, 5, 8'hB1);
    add(0, 0, 8'h00, 1, 4, 8'hB2);
    add(0, 0, 8'h00, 1, 3, 8'hB3);
    add(0, 0, 8'h00, 1, 2, 8'hB4);
    add(0, 0, 8'h00, 1, 1, 8'hB5);
    add(0, 0, 8'h00, 0, 0, 8'h00);
    // flush with a simultaneous push at count 3, then normal use again
    add(0, 1, 8'hC1, 0, 0, 8'h00);
    add(0, 1, 8'hC2, 0, 1, 8'hC1);
    add(0, 1, 8'hC3, 0, 2, 8'hC1);
    add(1, 1, 8'hC4, 0, 3, 8'hC1);
    add(0, 1, 8'hE1, 0, 0, 8'h00);
    add(0, 0, 8'h00, 1, 1, 8'hE1);
    add(0, 0, 8'h00, 0, 0, 8'h00);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].flush, vecs[i].vld, vecs[i].din, vecs[i].rdy);
      check_dut($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dout);
    end

    // steady streaming at count 2: output lags input by two entries
    drive(0, 1, 8'h20, 0);
    drive(0, 1, 8'h21, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 8'(8'h22 + i), 1);
      check_dut($sformatf("stream%0d", i), 2, 8'(8'h20 + i));
    end
    drive(0, 0, 8'h00, 1);
    check_dut("drain0", 2, 8'h2A);
    drive(0, 0, 8'h00, 1);
    check_dut("drain1", 1, 8'h2B);
    drive(0, 0, 8'h00, 0);
    check_dut("drained", 0, 8'h00);

    // asynchronous reset in the middle of a burst
    drive(0, 1, 8'h77, 0);
    drive(0, 1, 8'h78, 0);
    drive(0, 1, 8'h79, 0);
    check_dut("pre_rst", 2, 8'h77);
    #2;
    rst = 1'b1;
    vld = 1'b0;
    #1;
    check_dut("async_rst", 0, 8'h00);
    check("async_rst af", 32'(af), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 8'h00, 0);
    check_dut("post_rst", 0, 8'h00);

    // fall-through: bypass when both sides ready, stored when consumer stalls
    ft_drive(0, 8'h00, 0);
    ft_check("ft_idle", 0, 0, 8'h00);
    check("ft_idle flags", 32'({f_full, f_empty, f_in_ready, f_af, f_ae}), 32'(5'b01101));
    ft_drive(1, 8'hA5, 1);
    ft_check("ft_bypass", 0, 1, 8'hA5);
    ft_drive(0, 8'h00, 0);
    ft_check("ft_after_bypass", 0, 0, 8'h00);
    check("ft_after_bypass empty", 32'(f_empty), 32'(1));
    ft_drive(1, 8'hA5, 0);
    ft_check("ft_stall", 0, 1, 8'hA5);
    ft_drive(0, 8'h00, 0);
    ft_check("ft_stored", 1, 1, 8'hA5);
    ft_drive(1, 8'h3C, 1);
    ft_check("ft_nonempty_push", 1, 1, 8'hA5);
    ft_drive(0, 8'h00, 1);
    ft_check("ft_second", 1, 1, 8'h3C);
    ft_drive(0, 8'h00, 0);
    ft_check("ft_empty", 0, 0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
